// File: rtl/vreg_group_arbiter.sv
// vreg_group_arbiter
//
// Shares one vector-register-file access port between NUM_REQ requesters.
// Each requester asks for a register group (base address + RVV vlmul).
// Whole groups are granted round-robin and never interleaved. The granted
// group is then walked one register per cycle, with start/end beat flags.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester request pending
//   req_addr     per-requester group base address (slice i = requester i)
//   req_vlmul    per-requester vlmul encoding (slice i = requester i)
//   req_ready    one-hot combinational acceptance strobe
//   stall        port back-pressure; freezes the current beat while busy
//   port_en      registered beat valid
//   port_addr    registered register address for this beat
//   port_owner   registered index of the requester owning the beat
//   port_start   registered first-beat flag
//   port_end     registered last-beat flag
//   busy         a group is in flight
module vreg_group_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 2,
    parameter int OWNER_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*3-1:0]          req_vlmul,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          stall,
    output logic                          port_en,
    output logic [ADDR_WIDTH-1:0]         port_addr,
    output logic [OWNER_W-1:0]            port_owner,
    output logic                          port_start,
    output logic                          port_end,
    output logic                          busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Group length in beats; fractional and reserved encodings occupy one register.
    function automatic logic [3:0] group_len(input logic [2:0] vlmul);
        if (vlmul[2])
            return 4'd1;
        else
            return 4'd1 << vlmul[1:0];
    endfunction

    state_t                  r_state;
    logic [3:0]              r_cnt;      // beats remaining after the current one
    logic [OWNER_W-1:0]      r_rr_ptr;
    logic                    r_port_en;
    logic [ADDR_WIDTH-1:0]   r_port_addr;
    logic [OWNER_W-1:0]      r_port_owner;
    logic                    r_port_start;
    logic                    r_port_end;

    state_t                  w_state_nxt;
    logic [3:0]              w_cnt_nxt;
    logic [OWNER_W-1:0]      w_rr_ptr_nxt;
    logic                    w_port_en_nxt;
    logic [ADDR_WIDTH-1:0]   w_port_addr_nxt;
    logic [OWNER_W-1:0]      w_port_owner_nxt;
    logic                    w_port_start_nxt;
    logic                    w_port_end_nxt;

    logic                    w_found;
    logic [OWNER_W-1:0]      w_winner;
    logic                    w_last;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_win_addr;
    logic [2:0]              w_win_vlmul;
    logic [3:0]              w_win_len;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = OWNER_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_win_addr  = req_addr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_win_vlmul = req_vlmul[w_winner*3 +: 3];
    assign w_win_len   = group_len(w_win_vlmul);

    assign w_last   = (r_state == S_BUSY) && (r_cnt == 4'd0);
    // rst_n gates accept so req_ready stays low throughout reset.
    assign w_accept = rst_n && w_found &&
                      ((r_state == S_IDLE) || (w_last && !stall));

    // State and beat registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_rr_ptr     <= '0;
            r_port_en    <= 1'b0;
            r_port_addr  <= '0;
            r_port_owner <= '0;
            r_port_start <= 1'b0;
            r_port_end   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_port_en    <= w_port_en_nxt;
            r_port_addr  <= w_port_addr_nxt;
            r_port_owner <= w_port_owner_nxt;
            r_port_start <= w_port_start_nxt;
            r_port_end   <= w_port_end_nxt;
        end
    end

    // Next-state and next-beat logic
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_port_en_nxt    = r_port_en;
        w_port_addr_nxt  = r_port_addr;
        w_port_owner_nxt = r_port_owner;
        w_port_start_nxt = r_port_start;
        w_port_end_nxt   = r_port_end;

        if (w_accept) begin
            // New group: beat 0 next cycle, even straight after a last beat.
            w_state_nxt      = S_BUSY;
            w_cnt_nxt        = w_win_len - 4'd1;
            w_rr_ptr_nxt     = (w_winner == OWNER_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
            w_port_en_nxt    = 1'b1;
            w_port_addr_nxt  = w_win_addr;
            w_port_owner_nxt = w_winner;
            w_port_start_nxt = 1'b1;
            w_port_end_nxt   = (w_win_len == 4'd1);
        end else if (r_state == S_BUSY && !stall) begin
            if (w_last) begin
                w_state_nxt      = S_IDLE;
                w_port_en_nxt    = 1'b0;
                w_port_start_nxt = 1'b0;
                w_port_end_nxt   = 1'b0;
            end else begin
                // Address wraps naturally at 2^ADDR_WIDTH.
                w_cnt_nxt        = r_cnt - 4'd1;
                w_port_addr_nxt  = r_port_addr + 1'b1;
                w_port_start_nxt = 1'b0;
                w_port_end_nxt   = (r_cnt == 4'd1);
            end
        end
    end

    // Outputs
    always_comb begin
        req_ready = '0;
        if (w_accept)
            req_ready = NUM_REQ'(1) << w_winner;
    end

    assign port_en    = r_port_en;
    assign port_addr  = r_port_addr;
    assign port_owner = r_port_owner;
    assign port_start = r_port_start;
    assign port_end   = r_port_end;
    assign busy       = (r_state == S_BUSY);

endmodule

// File: tb/tb_vreg_group_arbiter.sv
module tb_vreg_group_arbiter;

    localparam int AW = 5;
    localparam int NR = 2;
    localparam int OW = 1;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*3-1:0]   req_vlmul;
    logic [NR-1:0]     req_ready;
    logic              stall;
    logic              port_en;
    logic [AW-1:0]     port_addr;
    logic [OW-1:0]     port_owner;
    logic              port_start;
    logic              port_end;
    logic              busy;

    int tests = 0;
    int fails = 0;

    vreg_group_arbiter #(.ADDR_WIDTH(AW), .NUM_REQ(NR), .OWNER_W(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_vlmul  (req_vlmul),
        .req_ready  (req_ready),
        .stall      (stall),
        .port_en    (port_en),
        .port_addr  (port_addr),
        .port_owner (port_owner),
        .port_start (port_start),
        .port_end   (port_end),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_port(input string tag, input logic en, input logic [AW-1:0] addr,
                            input logic st, input logic nd, input logic [OW-1:0] own,
                            input logic bz);
        chk({tag, ".en"},    32'(port_en),    32'(en));
        chk({tag, ".addr"},  32'(port_addr),  32'(addr));
        chk({tag, ".start"}, 32'(port_start), 32'(st));
        chk({tag, ".end"},   32'(port_end),   32'(nd));
        chk({tag, ".owner"}, 32'(port_owner), 32'(own));
        chk({tag, ".busy"},  32'(busy),       32'(bz));
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [2:0] m);
        req_valid[i]        = v;
        req_addr[i*AW +: AW] = a;
        req_vlmul[i*3 +: 3]  = m;
    endtask

    task automatic chk_ready(input string tag, input logic [NR-1:0] exp);
        #1;
        chk(tag, 32'(req_ready), 32'(exp));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_vlmul = '0;
        stall     = 1'b0;
        tick();

        // Reset state, with requests pending while reset is held
        set_req(0, 1'b1, 5'd3, 3'b000);
        set_req(1, 1'b1, 5'd9, 3'b000);
        chk_ready("rst.ready", 2'b00);
        chk_port("rst", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single request: addr 8, L=4
        set_req(0, 1'b1, 5'd8, 3'b010);
        chk_ready("single.ready", 2'b01);
        tick(); req_valid = '0;
        chk_port("single.b0", 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_port("single.b1", 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_port("single.b2", 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_port("single.b3", 1'b1, 5'd11, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_port("single.idle", 1'b0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0);

        // Round-robin contention from a fresh reset (rr_ptr = 0)
        do_reset();
        set_req(0, 1'b1, 5'd4,  3'b001);
        set_req(1, 1'b1, 5'd16, 3'b000);
        chk_ready("rr.ready0", 2'b01);
        tick(); req_valid = 2'b10;
        chk_port("rr.a0", 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_ready("rr.midgroup", 2'b00);
        tick();
        chk_port("rr.a1", 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_ready("rr.ready1", 2'b10);
        tick(); req_valid = 2'b00;
        chk_port("rr.b0", 1'b1, 5'd16, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_ready("rr.novalid", 2'b00);
        tick();
        chk_port("rr.idle", 1'b0, 5'd16, 1'b0, 1'b0, 1'b1, 1'b0);
        req_valid = 2'b11;
        chk_ready("rr.again0", 2'b01);
        tick(); req_valid = 2'b00;
        chk_port("rr.c0", 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        req_valid = 2'b11;
        chk_ready("rr.again1", 2'b10);
        tick(); req_valid = 2'b00;
        chk_port("rr.d0", 1'b1, 5'd16, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();

        // Wrap and fractional (rr_ptr = 0); stall ignored while idle
        stall = 1'b1;
        set_req(0, 1'b1, 5'd30, 3'b010);
        chk_ready("wrap.ready", 2'b01);
        tick(); req_valid = '0; stall = 1'b0;
        chk_port("wrap.b0", 1'b1, 5'd30, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_port("wrap.b1", 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_port("wrap.b2", 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_port("wrap.b3", 1'b1, 5'd1,  1'b0, 1'b1, 1'b0, 1'b1);
        set_req(0, 1'b1, 5'd7, 3'b111);
        chk_ready("frac.b2b", 2'b01);
        tick(); req_valid = '0;
        chk_port("frac.b0", 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_port("frac.idle", 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stall on beat 1, then stall on last beat with a pending request (rr_ptr = 1)
        set_req(1, 1'b1, 5'd20, 3'b010);
        chk_ready("stall.ready", 2'b10);
        tick(); req_valid = '0;
        chk_port("stall.b0", 1'b1, 5'd20, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); stall = 1'b1;
        chk_port("stall.b1", 1'b1, 5'd21, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk_port("stall.h1", 1'b1, 5'd21, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); stall = 1'b0;
        chk_port("stall.h2", 1'b1, 5'd21, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk_port("stall.b2", 1'b1, 5'd22, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk_port("stall.b3", 1'b1, 5'd23, 1'b0, 1'b1, 1'b1, 1'b1);
        set_req(0, 1'b1, 5'd2, 3'b000);
        stall = 1'b1;
        chk_ready("stall.noacc", 2'b00);
        tick(); stall = 1'b0;
        chk_port("stall.b3h", 1'b1, 5'd23, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_ready("stall.acc", 2'b01);
        tick(); req_valid = '0;
        chk_port("stall.n0", 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();

        // Reset mid-group on beat 2 of an L=8 group (rr_ptr = 1)
        set_req(0, 1'b1, 5'd10, 3'b011);
        chk_ready("mrst.ready", 2'b01);
        tick(); req_valid = '0;
        chk_port("mrst.b0", 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk_port("mrst.b2", 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        set_req(0, 1'b1, 5'd5,  3'b000);
        set_req(1, 1'b1, 5'd25, 3'b000);
        chk_ready("mrst.inrst", 2'b00);
        chk_port("mrst.zero", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        chk_ready("mrst.rrptr", 2'b01);
        tick(); req_valid = '0;
        chk_port("mrst.new", 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard bound on run length
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vreg_group_arbiter.md
# vreg_group_arbiter

Shares one vector-register-file access port between `NUM_REQ` requesters (e.g. ALU operand fetch, load/store unit). Each request names a register group as a base address plus `vlmul`. The arbiter grants whole groups round-robin and never interleaves two groups. It then steps the port through every register of the granted group, one per cycle, with start/end beat flags. It sits between the issue logic and the register-file port, in place of per-requester address generation.

## Interface
Parameters:
- `ADDR_WIDTH`, 5, vector register address width (32 registers)
- `NUM_REQ`, 2, number of requesters, legal range 2..4
- `OWNER_W`, `$clog2(NUM_REQ)`, width of owner index

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  request pending, one bit per requester
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  group base address; requester i occupies slice i
- `req_vlmul`  in  NUM_REQ*3  RVV vlmul encoding per requester
- `req_ready`  out  NUM_REQ  one-hot acceptance strobe
- `stall`  in  1  port back-pressure; freezes the current beat
- `port_en`  out  1  port beat valid
- `port_addr`  out  ADDR_WIDTH  register address for this beat
- `port_owner`  out  OWNER_W  index of the requester that owns this beat
- `port_start`  out  1  first beat of group
- `port_end`  out  1  last beat of group
- `busy`  out  1  a group is in flight

## Operation
- **Group length L:**
  - `vlmul[2]==0`: L = 1<<vlmul (1, 2, 4, 8).
  - `vlmul[2]==1` (fractional, including reserved 3'b100): L = 1.
- **Address arithmetic:** beat k uses address `base + k`, computed mod 2^ADDR_WIDTH. 30 with L=4 wraps to 30, 31, 0, 1. Base alignment is not checked.
- **States:** IDLE and BUSY. Internal registers: `cnt` (beats remaining, 4 bits), `rr_ptr` (highest-priority index).
- **Accept condition:** `accept = (IDLE | (BUSY & last beat & ~stall)) & |req_valid`.
- **Winner selection:** the first valid requester, searching from `rr_ptr` upward modulo NUM_REQ.
- **`req_ready`:** combinational, one-hot to the winner, high only when `accept` is true. The handshake completes when valid and ready are both high in the same cycle.
- **Requester obligations:** hold `req_valid` and payload stable until `req_ready`. Deasserting valid before ready is allowed and withdraws the request.
- **On accept:**
  - Latch base, L and owner.
  - `rr_ptr <= winner+1 mod NUM_REQ`.
  - Next state is BUSY.
- **BUSY without stall:** advance one beat per cycle.
- **After the last beat:** go to IDLE if no accept occurs that cycle; otherwise go directly to beat 0 of the new group (no bubble).
- **`stall` in BUSY:**
  - All `port_*` outputs, the counter and state hold.
  - No accept occurs.
  - `port_en` stays high.
  - `stall` is ignored in IDLE.
- **`busy`:** equals the BUSY state.
- **Reset (any time, including mid-group):** the group is aborted and not resumed. State IDLE, `rr_ptr=0`, all outputs 0 (`req_ready` 0 while `rst_n` low).

## Timing
- All `port_*` outputs and `busy` are registered.
- Accept in cycle T → beat 0 (`port_en=1`, `port_start=1`, `port_addr=base`) in cycle T+1.
- Beat L-1 appears in cycle T+L when there are no stalls; each stall cycle adds one.
- `port_end=1` on beat L-1. For L=1, `port_start` and `port_end` are both high on the single beat.
- Back-to-back groups: the accept happens during the last beat (cycle T+L), and the new beat 0 appears in T+L+1.
- `port_en` drops to 0 in the cycle after the last beat only when no accept occurred.
- Between beats, `port_owner` is constant for the whole group.

## Test plan
- **Single request:** req0 only, addr=8, vlmul=3'b010 accepted in T → `port_addr` 8, 9, 10, 11 in T+1..T+4; `port_start` in T+1 only; `port_end` in T+4 only; `busy` falls in T+5.
- **Round-robin contention:** req0 and req1 both valid from T after reset, addr 4/16, vlmul 3'b001/3'b000.
  - req0 is granted in T → 4, 5 in T+1..T+2.
  - req1 is granted in T+2 → 16 in T+3, with start and end both high.
  - Re-raise both → req0 wins next (rr_ptr=0 after req1's grant); repeat with rr_ptr=1 → req1 wins.
- **Wrap and fractional:** addr=30, vlmul=3'b010 → 30, 31, 0, 1. addr=7, vlmul=3'b111 → single beat 7, start and end both high.
- **Stall:** L=4 group with `stall` high for 2 cycles on beat 1 → `port_addr` holds beat 1 for 3 cycles; `port_end` appears 2 cycles later than the no-stall case; a pending request is not accepted during the stall.
- **Reset mid-group:** assert `rst_n=0` on beat 2 of an L=8 group → all outputs 0 immediately and `busy=0`. After release, a new request to req1 with req0 also valid → req0 granted (rr_ptr reset to 0).
